// File: rtl/rr_arb_4to1.sv
// rr_arb_4to1: four-requester round-robin arbiter with valid/ready on every
// port and a single registered output stage (1-cycle latency, full throughput).
// out_sel drives the downstream 4:1 word mux select; out_data carries the word.
// Optional feature macro: ARB_PKT_LOCK_EN (holds the grant on one requester
// until its in_last beat, so multi-beat packets are never interleaved).
module rr_arb_4to1 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        in_valid,
  output logic [3:0]        in_ready,
  input  logic [3:0]        in_last,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  input  logic [DATA_W-1:0] c_data,
  input  logic [DATA_W-1:0] d_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_sel,
  output logic [DATA_W-1:0] out_data
);

  logic              out_valid_q, out_valid_d;
  logic [1:0]        out_sel_q, out_sel_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        ptr_q, ptr_d;

  logic              load_en;
  logic [3:0]        eligible;
  logic              grant_found;
  logic [1:0]        grant_idx;
  logic [1:0]        cand;
  logic              xfer;
  logic [DATA_W-1:0] grant_data;

`ifdef ARB_PKT_LOCK_EN
  logic              lock_q, lock_d;
  logic [1:0]        owner_q, owner_d;
`else
  logic              unused_in_last;
  assign unused_in_last = ^in_last;
`endif

  // The output register can take a new word when empty or being drained.
  assign load_en = !out_valid_q || out_ready;

`ifdef ARB_PKT_LOCK_EN
  // While a packet is in flight only its owner may compete.
  always_comb begin
    eligible = in_valid;
    if (lock_q) begin
      eligible = in_valid & (4'b0001 << owner_q);
    end
  end
`else
  // Every valid requester competes each cycle.
  always_comb begin
    eligible = in_valid;
  end
`endif

  // Rotating priority search starting at ptr, wrapping 3 -> 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Single ready to the winner only; held low during reset and while stalled.
  always_comb begin
    in_ready = 4'b0000;
    xfer     = 1'b0;
    if (rst_n && grant_found && load_en) begin
      in_ready[grant_idx] = 1'b1;
      xfer                = 1'b1;
    end
  end

  // Payload select for the winning requester.
  always_comb begin
    grant_data = a_data;
    case (grant_idx)
      2'd0:    grant_data = a_data;
      2'd1:    grant_data = b_data;
      2'd2:    grant_data = c_data;
      default: grant_data = d_data;
    endcase
  end

  // Next-state for the output stage, priority pointer and packet lock.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    out_data_d  = out_data_q;
    ptr_d       = ptr_q;
`ifdef ARB_PKT_LOCK_EN
    lock_d      = lock_q;
    owner_d     = owner_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_sel_d   = grant_idx;
      out_data_d  = grant_data;
      ptr_d       = grant_idx + 2'd1;
`ifdef ARB_PKT_LOCK_EN
      if (!in_last[grant_idx]) begin
        lock_d  = 1'b1;
        owner_d = grant_idx;
        ptr_d   = ptr_q;
      end else begin
        lock_d  = 1'b0;
      end
`endif
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any pending word and rewinds the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sel_q   <= 2'd0;
      out_data_q  <= '0;
      ptr_q       <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_data_q  <= out_data_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef ARB_PKT_LOCK_EN
  // Packet lock registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q  <= 1'b0;
      owner_q <= 2'd0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_rr_arb_4to1.sv
// tb_rr_arb_4to1: scoreboard bench for rr_arb_4to1 with a behavioural
// round-robin reference model; honours ARB_PKT_LOCK_EN when defined.
module tb_rr_arb_4to1;

  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic [3:0]        in_valid;
  logic [3:0]        in_ready;
  logic [3:0]        in_last;
  logic [DATA_W-1:0] a_data, b_data, c_data, d_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_sel;
  logic [DATA_W-1:0] out_data;

  typedef struct packed {
    logic [1:0]        sel;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int   mPtr   = 0;
  bit   mValid = 0;
  bit   mLock  = 0;
  int   mOwner = 0;

  logic [DATA_W-1:0] pay [4];

  rr_arb_4to1 #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .a_data   (a_data),
    .b_data   (b_data),
    .c_data   (c_data),
    .d_data   (d_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sel  (out_sel),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then step the model and
  // check the combinational ready it implies for the coming rising edge.
  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] last, input logic ordy);
    logic [3:0] expReady;
    bit         loadEn;
    bit         found;
    int         g;
    exp_t       e;
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = v;
    in_last   = last;
    out_ready = ordy;
    a_data    = pay[0];
    b_data    = pay[1];
    c_data    = pay[2];
    d_data    = pay[3];
    #1;
    expReady = 4'b0000;
    loadEn   = !mValid || ordy;
    found    = 0;
    g        = 0;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (mPtr + k) % 4;
      if (!found && v[idx] && (!mLock || idx == mOwner)) begin
        found = 1;
        g     = idx;
      end
    end
    if (loadEn) begin
      if (found) begin
        expReady[g] = 1'b1;
        e.sel  = 2'(g);
        e.data = pay[g];
        expQ.push_back(e);
        mValid = 1;
`ifdef ARB_PKT_LOCK_EN
        if (!last[g]) begin
          mLock  = 1;
          mOwner = g;
        end else begin
          mLock = 0;
          mPtr  = (g + 1) % 4;
        end
`else
        mPtr = (g + 1) % 4;
`endif
      end else begin
        mValid = 0;
      end
    end
    checkOutput("in_ready", 64'(in_ready), 64'(expReady));
  endtask

  // Assert reset for a few cycles; any pending word is lost.
  task automatic doReset(input int cycles);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 4'b1111;
    mPtr     = 0;
    mValid   = 0;
    mLock    = 0;
    mOwner   = 0;
    expQ.delete();
    for (int i = 0; i < cycles; i++) begin
      #1;
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_sel",   64'(out_sel),   64'd0);
      checkOutput("rst_out_data",  64'(out_data),  64'd0);
      checkOutput("rst_in_ready",  64'(in_ready),  64'd0);
      @(negedge clk);
    end
  endtask

  // Monitor: a word leaving the output register is compared with the oldest
  // expected word.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got sel %0d data 0x%0h expected none", out_sel, out_data);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("out_sel",  64'(out_sel),  64'(e.sel));
          checkOutput("out_data", 64'(out_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    pay[0] = 32'h0000_000A;
    pay[1] = 32'h0000_000B;
    pay[2] = 32'h0000_000C;
    pay[3] = 32'h0000_000D;
    a_data = pay[0];
    b_data = pay[1];
    c_data = pay[2];
    d_data = pay[3];

    $display("[TB] reset");
    doReset(3);

    $display("[TB] rotation");
    for (int i = 0; i < 8; i++) applyStimulus(4'b1111, 4'b1111, 1'b1);

    $display("[TB] sparse");
    for (int i = 0; i < 4; i++) applyStimulus(4'b1010, 4'b1111, 1'b1);

    $display("[TB] back-pressure");
    applyStimulus(4'b0100, 4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(4'b1111, 4'b1111, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(4'b1111, 4'b1111, 1'b1);

    $display("[TB] packet");
    applyStimulus(4'b0001, 4'b1111, 1'b1);
    applyStimulus(4'b1111, 4'b1101, 1'b1);
    applyStimulus(4'b1111, 4'b1101, 1'b1);
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    applyStimulus(4'b1111, 4'b1111, 1'b1);

    $display("[TB] drain");
    pay[2] = 32'hDEAD_BEEF;
    applyStimulus(4'b0100, 4'b1111, 1'b1);
    applyStimulus(4'b0000, 4'b1111, 1'b1);
    applyStimulus(4'b0000, 4'b1111, 1'b1);

    $display("[TB] random");
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 4; r++) pay[r] = $urandom;
      applyStimulus(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] mid-run reset");
    doReset(2);
    for (int i = 0; i < 100; i++) begin
      for (int r = 0; r < 4; r++) pay[r] = $urandom;
      applyStimulus(4'($urandom), ($urandom_range(0, 3) != 0) ? 4'b1111 : 4'($urandom),
                    ($urandom_range(0, 3) != 0));
    end

    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 4'b1111, 1'b1);
    @(negedge clk);
    #3;
    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    checkOutput("final_out_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
